// File: rtl/dense_pkg.sv
// Shared definitions for the dense-layer requantization stage:
// accumulator width helper, FSM state type and the signed saturation function.
package dense_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, EMIT} dense_rq_state_t;

    // Accumulator results are twice as wide as the layer's data words.
    function automatic int acc_w(input int width);
        return 2 * width;
    endfunction

    // Clamp a sign-extended value into the signed range of a w-bit word.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                      input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/requant_lane.sv
// One requantization lane: bias add, round-half-up shift, optional ReLU and
// saturation of a single accumulator element to WIDTH bits.
// Build option: DENSE_REQUANT_RELU_EN enables the ReLU clamp.
module requant_lane
    import dense_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHIFT = 8
) (
    input  logic signed [2*WIDTH-1:0] acc,
    input  logic signed [WIDTH-1:0]   bias,
    output logic signed [WIDTH-1:0]   res
);

    // Two guard bits keep the bias add and rounding offset from wrapping.
    localparam int T_W = acc_w(WIDTH) + 2;
    // Half an output LSB; evaluates to zero when SHIFT is zero.
    localparam logic signed [T_W-1:0] RND = (T_W'(1) << SHIFT) >> 1;

    logic signed [T_W-1:0] sum;
    logic signed [T_W-1:0] rounded;
    logic signed [T_W-1:0] shifted;
    logic signed [T_W-1:0] clamped;
    logic signed [63:0]    wide;

    // Pure datapath: sum, round, shift, clamp, saturate.
    always_comb begin
        sum     = {{(T_W-2*WIDTH){acc[2*WIDTH-1]}}, acc}
                + {{(T_W-WIDTH){bias[WIDTH-1]}}, bias};
        rounded = sum + RND;
        shifted = rounded >>> SHIFT;
`ifdef DENSE_REQUANT_RELU_EN
        clamped = (shifted < 0) ? '0 : shifted;
`else
        clamped = shifted;
`endif
        wide    = {{(64-T_W){clamped[T_W-1]}}, clamped};
        res     = WIDTH'(sat_signed(wide, WIDTH));
    end

endmodule

// File: rtl/dense_requant_stage.sv
// Captures a B x M accumulator matrix plus per-neuron bias, requantizes it
// and streams one row of M results per beat on a valid/ready interface.
// Build option: DENSE_REQUANT_RELU_EN enables ReLU in every lane.
module dense_requant_stage
    import dense_pkg::*;
#(
    parameter int B     = 2,
    parameter int M     = 3,
    parameter int WIDTH = 16,
    parameter int SHIFT = 8,
    localparam int IDX_W = (B > 1) ? $clog2(B) : 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic signed [B-1:0][M-1:0][2*WIDTH-1:0] acc,
    input  logic signed [M-1:0][WIDTH-1:0]          bias,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic signed [M-1:0][WIDTH-1:0]          out_row,
    output logic [IDX_W-1:0]                        out_idx,
    output logic                                    out_last
);

    localparam int ACC_W = acc_w(WIDTH);
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(B - 1);

    dense_rq_state_t                     state_q, state_d;
    logic [IDX_W-1:0]                    row_q, row_d;
    logic [B-1:0][M-1:0][ACC_W-1:0]      acc_q, acc_d;
    logic [M-1:0][WIDTH-1:0]             bias_q, bias_d;
    logic [M-1:0][WIDTH-1:0]             out_row_q, out_row_d;
    logic [IDX_W-1:0]                    sel;
    logic signed [M-1:0][WIDTH-1:0]      lane_res;

    // Row fed to the lanes: row 0 while loading, otherwise the next row so it
    // is ready on the same edge the current row is accepted.
    always_comb begin
        sel = '0;
        if (state_q == EMIT && row_q != LAST_ROW) begin
            sel = row_q + 1'b1;
        end
    end

    for (genvar i = 0; i < M; i++) begin : g_lane
        requant_lane #(
            .WIDTH (WIDTH),
            .SHIFT (SHIFT)
        ) u_lane (
            .acc  (acc_q[sel][i]),
            .bias (bias_q[i]),
            .res  (lane_res[i])
        );
    end

    // Next-state logic for capture, first-row load and row streaming.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        acc_d     = acc_q;
        bias_d    = bias_q;
        out_row_d = out_row_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d   = acc;
                    bias_d  = bias;
                    row_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                out_row_d = lane_res;
                row_d     = '0;
                state_d   = EMIT;
            end
            EMIT: begin
                if (out_ready) begin
                    if (row_q == LAST_ROW) begin
                        state_d = IDLE;
                    end else begin
                        row_d     = row_q + 1'b1;
                        out_row_d = lane_res;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any matrix in flight and clears buffers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            row_q     <= '0;
            acc_q     <= '0;
            bias_q    <= '0;
            out_row_q <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            acc_q     <= acc_d;
            bias_q    <= bias_d;
            out_row_q <= out_row_d;
        end
    end

    // Handshake outputs decode directly from registered state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == EMIT);
        out_last  = (state_q == EMIT) && (row_q == LAST_ROW);
        out_idx   = row_q;
        out_row   = out_row_q;
    end

endmodule
